// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and constants for the ID-stage hazard/stall sequencer.
package pipe_pkg;
  typedef enum logic {RUN, MC_WAIT} state_t;
  localparam int REG_W_DEF = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (inc && cnt != '1) cnt <= cnt + W'(1);
endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use bubbles, branch flushes and multi-cycle EX freezes with perf counters.
module hazard_stall_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_W       = REG_W_DEF,
  parameter int MC_TIMEOUT  = 32,
  parameter int STALL_CNT_W = 16,
  parameter int FLUSH_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [REG_W-1:0]       idOp1,
  input  logic [REG_W-1:0]       idOp2,
  input  logic                   idUseOp1,
  input  logic                   idUseOp2,
  input  logic                   idMcOp,
  input  logic [REG_W-1:0]       exRd,
  input  logic                   exMemRead,
  input  logic                   branchTaken,
  input  logic                   mcDone,
  output logic                   pcWrite,
  output logic                   ifIdWrite,
  output logic                   idExWrite,
  output logic                   ifIdFlush,
  output logic                   idExFlush,
  output logic                   exMemFlush,
  output logic                   mcStart,
  output logic                   mcError,
  output logic [STALL_CNT_W-1:0] stallCycles,
  output logic [FLUSH_CNT_W-1:0] flushCount
);
  state_t     state, next_state;
  logic [7:0] wait_cnt, next_cnt;
  logic       load_use, set_err, flush_inc;
  assign load_use = exMemRead & ((idUseOp1 & (exRd == idOp1)) | (idUseOp2 & (exRd == idOp2)));
  always_comb begin
    pcWrite    = 1'b1;
    ifIdWrite  = 1'b1;
    idExWrite  = 1'b1;
    ifIdFlush  = 1'b0;
    idExFlush  = 1'b0;
    exMemFlush = 1'b0;
    mcStart    = 1'b0;
    next_state = state;
    next_cnt   = wait_cnt;
    set_err    = 1'b0;
    flush_inc  = 1'b0;
    if (state == RUN) begin
      if (branchTaken) begin
        ifIdFlush = 1'b1;
        idExFlush = 1'b1;
        flush_inc = 1'b1;
      end else if (load_use) begin
        pcWrite   = 1'b0;
        ifIdWrite = 1'b0;
        idExFlush = 1'b1;
      end else if (idMcOp) begin
        next_state = MC_WAIT;
        next_cnt   = 8'd0;
      end
    end else if (wait_cnt != 8'd0 && (mcDone || wait_cnt == 8'(MC_TIMEOUT - 1))) begin
      // done beats timeout when both land in the same cycle
      next_state = RUN;
      set_err    = ~mcDone;
    end else begin
      pcWrite    = 1'b0;
      ifIdWrite  = 1'b0;
      idExWrite  = 1'b0;
      exMemFlush = 1'b1;
      mcStart    = (wait_cnt == 8'd0);
      next_cnt   = wait_cnt + 8'd1;
    end
    if (rst) begin
      pcWrite    = 1'b0;
      ifIdWrite  = 1'b0;
      idExWrite  = 1'b0;
      ifIdFlush  = 1'b0;
      idExFlush  = 1'b0;
      exMemFlush = 1'b0;
      mcStart    = 1'b0;
      flush_inc  = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= RUN;
      wait_cnt <= 8'd0;
      mcError  <= 1'b0;
    end else begin
      state    <= next_state;
      wait_cnt <= next_cnt;
      mcError  <= mcError | set_err;
    end
  sat_counter #(.W(STALL_CNT_W)) u_stall (
    .clk(clk), .rst(rst), .inc(~pcWrite & ~rst), .cnt(stallCycles)
  );
  sat_counter #(.W(FLUSH_CNT_W)) u_flush (
    .clk(clk), .rst(rst), .inc(flush_inc), .cnt(flushCount)
  );
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed vectors into a scoreboard queue, checked by a negedge monitor.
module tb_hazard_stall_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic [3:0] idOp1 = '0, idOp2 = '0, exRd = '0;
  logic idUseOp1 = 0, idUseOp2 = 0, idMcOp = 0, exMemRead = 0, branchTaken = 0, mcDone = 0;
  logic pcWrite, ifIdWrite, idExWrite, ifIdFlush, idExFlush, exMemFlush, mcStart, mcError;
  logic [15:0] stallCycles;
  logic [1:0]  flushCount;
  int n_vec = 0, n_miss = 0;
  typedef struct {
    string      name;
    logic [6:0] ctl;
    logic       err;
    int         st;
    int         fl;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  logic [6:0] act;
  hazard_stall_ctrl #(.REG_W(4), .MC_TIMEOUT(4), .STALL_CNT_W(16), .FLUSH_CNT_W(2)) dut (
    .clk(clk), .rst(rst), .idOp1(idOp1), .idOp2(idOp2), .idUseOp1(idUseOp1), .idUseOp2(idUseOp2),
    .idMcOp(idMcOp), .exRd(exRd), .exMemRead(exMemRead), .branchTaken(branchTaken), .mcDone(mcDone),
    .pcWrite(pcWrite), .ifIdWrite(ifIdWrite), .idExWrite(idExWrite), .ifIdFlush(ifIdFlush),
    .idExFlush(idExFlush), .exMemFlush(exMemFlush), .mcStart(mcStart), .mcError(mcError),
    .stallCycles(stallCycles), .flushCount(flushCount)
  );
  always #5 clk = ~clk;
  // ctl = {pcWrite,ifIdWrite,idExWrite,ifIdFlush,idExFlush,exMemFlush,mcStart}
  localparam logic [6:0] C_RST = 7'b000_0000, C_RUN = 7'b111_0000, C_LU = 7'b001_0100;
  localparam logic [6:0] C_BR = 7'b111_1100, C_MCS = 7'b000_0011, C_MCW = 7'b000_0010;
  task automatic vec(input string nm, input logic r, input logic [3:0] o1, o2, input logic u1, u2, mc,
                     input logic [3:0] rd, input logic mr, br, dn,
                     input logic [6:0] c, input logic er, input int s, f);
    exp_t x;
    @(posedge clk);
    #1;
    rst = r; idOp1 = o1; idOp2 = o2; idUseOp1 = u1; idUseOp2 = u2; idMcOp = mc;
    exRd = rd; exMemRead = mr; branchTaken = br; mcDone = dn;
    x.name = nm; x.ctl = c; x.err = er; x.st = s; x.fl = f;
    sb.push_back(x);
  endtask
  task automatic idle(input string nm, input logic [6:0] c, input logic er, input int s, f);
    vec(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, c, er, s, f);
  endtask
  task automatic mcop(input string nm, input logic er, input int s, f);
    vec(nm, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, C_RUN, er, s, f);
  endtask
  always @(negedge clk)
    if (sb.size() > 0) begin
      e = sb.pop_front();
      n_vec++;
      act = {pcWrite, ifIdWrite, idExWrite, ifIdFlush, idExFlush, exMemFlush, mcStart};
      if (act !== e.ctl) begin
        n_miss++;
        $display("FAIL %s ctl got %b want %b", e.name, act, e.ctl);
      end
      if (mcError !== e.err) begin
        n_miss++;
        $display("FAIL %s mcError got %b want %b", e.name, mcError, e.err);
      end
      if (32'(stallCycles) !== e.st) begin
        n_miss++;
        $display("FAIL %s stallCycles got %0d want %0d", e.name, stallCycles, e.st);
      end
      if (32'(flushCount) !== e.fl) begin
        n_miss++;
        $display("FAIL %s flushCount got %0d want %0d", e.name, flushCount, e.fl);
      end
    end
  initial begin
    vec("reset", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RST, 0, 0, 0);
    idle("run_default", C_RUN, 0, 0, 0);
    vec("load_use", 0, 3, 0, 1, 0, 0, 3, 1, 0, 0, C_LU, 0, 0, 0);
    idle("after_lu", C_RUN, 0, 1, 0);
    vec("load_unused_op", 0, 0, 5, 1, 0, 0, 5, 1, 0, 0, C_RUN, 0, 1, 0);
    vec("branch_vs_lu", 0, 3, 0, 1, 0, 0, 3, 1, 1, 0, C_BR, 0, 1, 0);
    idle("after_br", C_RUN, 0, 1, 1);
    mcop("mc_issue", 0, 1, 1);
    vec("mc_start_ign", 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, C_MCS, 0, 1, 1);
    idle("mc_wait1", C_MCW, 0, 2, 1);
    idle("mc_wait2", C_MCW, 0, 3, 1);
    vec("mc_done_at_to", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, C_RUN, 0, 4, 1);
    idle("mc_back_run", C_RUN, 0, 4, 1);
    mcop("mc2_issue", 0, 4, 1);
    idle("mc2_start", C_MCS, 0, 4, 1);
    vec("mc2_done_early", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, C_RUN, 0, 5, 1);
    idle("mc2_back_run", C_RUN, 0, 5, 1);
    mcop("to_issue", 0, 5, 1);
    idle("to_start", C_MCS, 0, 5, 1);
    idle("to_wait1", C_MCW, 0, 6, 1);
    idle("to_wait2", C_MCW, 0, 7, 1);
    idle("to_release", C_RUN, 0, 8, 1);
    idle("to_error", C_RUN, 1, 8, 1);
    mcop("rst_mc_issue", 1, 8, 1);
    idle("rst_mc_start", C_MCS, 1, 8, 1);
    vec("rst_mid_wait", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RST, 0, 0, 0);
    #6 rst = 1'b0;
    idle("after_rst", C_RUN, 0, 0, 0);
    vec("lu_over_mc", 0, 7, 0, 1, 0, 1, 7, 1, 0, 0, C_LU, 0, 0, 0);
    idle("no_mc_entered", C_RUN, 0, 1, 0);
    for (int i = 0; i < 4; i++)
      vec("flush_sat", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_BR, 0, 1, i);
    idle("flush_held", C_RUN, 0, 1, 3);
    repeat (2) @(posedge clk);
    if (sb.size() != 0) begin
      n_miss++;
      $display("FAIL drain pending got %0d want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
